warp_xdiv: RTL and testbench

Integer divide/remainder execution unit fed by the issue stage's xdiv dispatch interface.
- Accepts one instruction at a time from issue (valid/ready), with operands read from the register file on the dispatch edge.
- Performs an iterative radix-2 restoring division and presents the result to writeback with a valid/ready handshake.
- On writeback it returns the instruction's reservation mask so issue can free the register reservations.

---
 rtl/warp_xdiv_pkg.sv | 29 ++
 rtl/warp_xdiv_if.sv | 33 +++
 rtl/warp_xdiv_step.sv | 29 ++
 rtl/warp_xdiv.sv | 171 +++++++++++++++++
 tb/tb_warp_xdiv.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/warp_xdiv_pkg.sv
// Shared definitions for the xdiv execution unit: pipeline code, datapath width,
// control-field layout and FSM state encoding.
package warp_xdiv_pkg;

  localparam int XDIV_XLEN      = 64;
  localparam int XDIV_LOG2_XLEN = 6;

  // Issue-stage pipeline code that routes an instruction to this unit
  localparam logic [3:0] PIPE_XDIV = 4'd6;

  // Bit positions of the xdiv control field carried with a dispatched op
  localparam int XDIV_CTRL_UNSIGNED = 0;
  localparam int XDIV_CTRL_WORD     = 1;
  localparam int XDIV_CTRL_REM      = 2;
  localparam int XDIV_CTRL_W        = 3;

  typedef struct packed {
    logic rem;
    logic word;
    logic is_unsigned;
  } xdiv_ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } xdiv_state_e;

endpackage

// File: rtl/warp_xdiv_if.sv
// Dispatch and writeback handshake bundle between issue/writeback and the xdiv unit.
// Signal names keep the unit-side i_/o_ direction prefixes.
interface warp_xdiv_if #(
  parameter int XLEN = warp_xdiv_pkg::XDIV_XLEN
);

  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_op1;
  logic [XLEN-1:0] i_op2;
  logic            i_unsigned;
  logic            i_word;
  logic            i_rem;
  logic [4:0]      i_rd;
  logic [31:0]     i_mask;

  logic            o_wb_valid;
  logic            i_wb_ready;
  logic [4:0]      o_wb_rd;
  logic [XLEN-1:0] o_wb_data;
  logic [31:0]     o_retire;

  modport master (
    output i_valid, i_op1, i_op2, i_unsigned, i_word, i_rem, i_rd, i_mask, i_wb_ready,
    input  o_ready, o_wb_valid, o_wb_rd, o_wb_data, o_retire
  );

  modport slave (
    input  i_valid, i_op1, i_op2, i_unsigned, i_word, i_rem, i_rd, i_mask, i_wb_ready,
    output o_ready, o_wb_valid, o_wb_rd, o_wb_data, o_retire
  );

endinterface

// File: rtl/warp_xdiv_step.sv
// One radix-2 restoring division iteration on magnitudes; purely combinational
// so the top can instantiate it once per cycle or unroll it later.
module warp_xdiv_step #(
  parameter int XLEN = warp_xdiv_pkg::XDIV_XLEN
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_dsor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            borrow;
  logic            unused_hi;

  // rem < divisor on entry, so a restored shifted value always fits in XLEN bits
  always_comb begin
    shifted = {i_rem, i_quot[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, i_dsor};
    borrow  = diff[XLEN+1];
    o_rem   = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    o_quot  = {i_quot[XLEN-2:0], ~borrow};
  end

  assign unused_hi = ^{shifted[XLEN], diff[XLEN]};

endmodule

// File: rtl/warp_xdiv.sv
// Iterative integer divide/remainder unit: accepts one op from issue, runs N
// restoring steps, and returns the result plus reservation mask to writeback.
module warp_xdiv
  import warp_xdiv_pkg::*;
#(
  parameter int XLEN      = XDIV_XLEN,
  parameter int LOG2_XLEN = XDIV_LOG2_XLEN
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  warp_xdiv_if.slave xif
);

  localparam logic [XLEN-1:0]      MIN_XLEN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]      MIN_WORD = {{(XLEN-31){1'b1}}, 31'd0};
  localparam logic [LOG2_XLEN-1:0] CNT_XLEN = LOG2_XLEN'(XLEN-1);
  localparam logic [LOG2_XLEN-1:0] CNT_WORD = LOG2_XLEN'(31);

  function automatic logic [XLEN-1:0] fit(input logic word, input logic [XLEN-1:0] v);
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  xdiv_state_e           state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [31:0]           mask_q, mask_d;
  xdiv_ctrl_t            ctrl_q, ctrl_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [LOG2_XLEN-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]       prem_q, prem_d;
  logic [XLEN-1:0]       quot_q, quot_d;
  logic [XLEN-1:0]       dsor_q, dsor_d;

  logic                  is_signed, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0]       a_eff, b_eff, a_abs, b_abs, special_res;
  logic [XLEN-1:0]       step_rem, step_quot, fin_rem, fin_quot;

  // Operands extended to the effective width, then split into sign and magnitude
  always_comb begin
    is_signed = !xif.i_unsigned;
    if (xif.i_word) begin
      a_eff = {{(XLEN-32){is_signed & xif.i_op1[31]}}, xif.i_op1[31:0]};
      b_eff = {{(XLEN-32){is_signed & xif.i_op2[31]}}, xif.i_op2[31:0]};
    end else begin
      a_eff = xif.i_op1;
      b_eff = xif.i_op2;
    end
    a_neg    = is_signed & a_eff[XLEN-1];
    b_neg    = is_signed & b_eff[XLEN-1];
    a_abs    = a_neg ? -a_eff : a_eff;
    b_abs    = b_neg ? -b_eff : b_eff;
    div_zero = (b_eff == '0);
    overflow = is_signed && (a_eff == (xif.i_word ? MIN_WORD : MIN_XLEN)) && (b_eff == '1);
    if (div_zero) special_res = xif.i_rem ? a_eff : '1;
    else          special_res = xif.i_rem ? '0 : a_eff;
  end

  warp_xdiv_step #(.XLEN(XLEN)) u_step (
    .i_rem  (prem_q),
    .i_quot (quot_q),
    .i_dsor (dsor_q),
    .o_rem  (step_rem),
    .o_quot (step_quot)
  );

  assign fin_quot = neg_quot_q ? -step_quot : step_quot;
  assign fin_rem  = neg_rem_q  ? -step_rem  : step_rem;

  // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    mask_d     = mask_q;
    ctrl_d     = ctrl_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    cnt_d      = cnt_q;
    prem_d     = prem_q;
    quot_d     = quot_q;
    dsor_d     = dsor_q;
    case (state_q)
      IDLE: begin
        if (xif.i_valid && ready_q) begin
          ready_d = 1'b0;
          wb_rd_d = xif.i_rd;
          mask_d  = xif.i_mask;
          ctrl_d  = '{rem: xif.i_rem, word: xif.i_word, is_unsigned: xif.i_unsigned};
          if (div_zero || overflow) begin
            wb_data_d  = fit(xif.i_word, special_res);
            wb_valid_d = 1'b1;
            state_d    = DONE;
          end else begin
            // Word dividends start in the top half so 32 shifts consume them exactly
            prem_d     = '0;
            quot_d     = xif.i_word ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
            dsor_d     = b_abs;
            cnt_d      = xif.i_word ? CNT_WORD : CNT_XLEN;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        prem_d = step_rem;
        quot_d = step_quot;
        if (cnt_q == '0) begin
          wb_data_d  = fit(ctrl_q.word, ctrl_q.rem ? fin_rem : fin_quot);
          wb_valid_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - LOG2_XLEN'(1);
        end
      end
      DONE: begin
        if (xif.i_wb_ready) begin
          wb_valid_d = 1'b0;
          ready_d    = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      mask_q     <= '0;
      ctrl_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      prem_q     <= '0;
      quot_q     <= '0;
      dsor_q     <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      mask_q     <= mask_d;
      ctrl_q     <= ctrl_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      cnt_q      <= cnt_d;
      prem_q     <= prem_d;
      quot_q     <= quot_d;
      dsor_q     <= dsor_d;
    end
  end

  assign xif.o_ready    = ready_q;
  assign xif.o_wb_valid = wb_valid_q;
  assign xif.o_wb_rd    = wb_rd_q;
  assign xif.o_wb_data  = wb_data_q;
  assign xif.o_retire   = (wb_valid_q && xif.i_wb_ready) ? mask_q : '0;

endmodule

// File: tb/tb_warp_xdiv.sv
// Self-checking bench for warp_xdiv: directed and random divide/remainder ops
// compared against an arithmetic reference model, plus latency/handshake/reset checks.
module tb_warp_xdiv;
  import warp_xdiv_pkg::*;

  localparam int XLEN      = XDIV_XLEN;
  localparam int LAT_LIMIT = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   retire_pulses = 0;

  warp_xdiv_if #(.XLEN(XLEN)) xif ();

  warp_xdiv #(.XLEN(XLEN), .LOG2_XLEN(XDIV_LOG2_XLEN)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .xif     (xif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (xif.o_retire != '0) retire_pulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M-extension divide semantics using native arithmetic.
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic uns, input logic word, input logic rem);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              sa32, sb32;
    int unsigned     ua32, ub32;
    logic [31:0]     r32;
    logic [63:0]     r64;
    if (word) begin
      ua32 = a[31:0]; ub32 = b[31:0];
      sa32 = a[31:0]; sb32 = b[31:0];
      if (ub32 == 0)                                  r32 = rem ? a[31:0] : 32'hFFFF_FFFF;
      else if (uns)                                   r32 = rem ? ua32 % ub32 : ua32 / ub32;
      else if (a[31:0] == 32'h8000_0000 && sb32 == -1) r32 = rem ? 32'd0 : a[31:0];
      else if (rem)                                   r32 = sa32 % sb32;
      else                                            r32 = sa32 / sb32;
      return {{32{r32[31]}}, r32};
    end
    ua = a; ub = b; sa = a; sb = b;
    if (ub == 0)                                       r64 = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (uns)                                      r64 = rem ? ua % ub : ua / ub;
    else if (a == 64'h8000_0000_0000_0000 && sb == -1) r64 = rem ? 64'd0 : a;
    else if (rem)                                      r64 = sa % sb;
    else                                               r64 = sa / sb;
    return r64;
  endfunction

  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic uns, input logic word);
    logic zero, ovf;
    if (word) begin
      zero = (b[31:0] == 32'd0);
      ovf  = !uns && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end else begin
      zero = (b == 64'd0);
      ovf  = !uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF;
    end
    if (zero || ovf) return 1;
    return word ? 33 : 65;
  endfunction

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic uns, input logic word, input logic rem, input int hold);
    logic [63:0] exp_d;
    logic [4:0]  rd;
    logic [31:0] mask;
    int          exp_lat, lat, pulses0;
    exp_d   = ref_div(a, b, uns, word, rem);
    exp_lat = ref_lat(a, b, uns, word);
    rd      = 5'($urandom);
    mask    = $urandom | 32'd1;
    @(negedge clk);
    check({tag, ":ready_idle"}, 64'(xif.o_ready), 64'd1);
    xif.i_valid = 1'b1; xif.i_op1 = a; xif.i_op2 = b;
    xif.i_unsigned = uns; xif.i_word = word; xif.i_rem = rem;
    xif.i_rd = rd; xif.i_mask = mask;
    @(negedge clk);
    xif.i_valid = 1'b0;
    xif.i_op1 = {$urandom, $urandom}; xif.i_op2 = {$urandom, $urandom};
    xif.i_unsigned = 1'($urandom); xif.i_word = 1'($urandom); xif.i_rem = 1'($urandom);
    xif.i_rd = 5'($urandom); xif.i_mask = $urandom;
    check({tag, ":ready_busy"}, 64'(xif.o_ready), 64'd0);
    lat = 1;
    while (!xif.o_wb_valid && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ":data"}, xif.o_wb_data, exp_d);
    check({tag, ":rd"}, 64'(xif.o_wb_rd), 64'(rd));
    pulses0 = retire_pulses;
    for (int i = 0; i < hold; i++) begin
      check({tag, ":hold_retire"}, 64'(xif.o_retire), 64'd0);
      check({tag, ":hold_ready"}, 64'(xif.o_ready), 64'd0);
      @(negedge clk);
      check({tag, ":hold_valid"}, 64'(xif.o_wb_valid), 64'd1);
      check({tag, ":hold_data"}, xif.o_wb_data, exp_d);
      check({tag, ":hold_rd"}, 64'(xif.o_wb_rd), 64'(rd));
    end
    xif.i_wb_ready = 1'b1;
    #1;
    check({tag, ":retire"}, 64'(xif.o_retire), 64'(mask));
    @(negedge clk);
    xif.i_wb_ready = 1'b0;
    #1;
    check({tag, ":retire_after"}, 64'(xif.o_retire), 64'd0);
    check({tag, ":valid_after"}, 64'(xif.o_wb_valid), 64'd0);
    check({tag, ":ready_after"}, 64'(xif.o_ready), 64'd1);
    check({tag, ":retire_pulses"}, 64'(retire_pulses - pulses0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":ready"}, 64'(xif.o_ready), 64'd1);
    check({tag, ":wb_valid"}, 64'(xif.o_wb_valid), 64'd0);
    check({tag, ":retire"}, 64'(xif.o_retire), 64'd0);
    check({tag, ":wb_data"}, xif.o_wb_data, 64'd0);
    check({tag, ":wb_rd"}, 64'(xif.o_wb_rd), 64'd0);
  endtask

  initial begin
    logic [63:0] a, b;
    logic        uns, word, rem;
    int          pulses0;

    xif.i_valid = 1'b0; xif.i_op1 = '0; xif.i_op2 = '0;
    xif.i_unsigned = 1'b0; xif.i_word = 1'b0; xif.i_rem = 1'b0;
    xif.i_rd = '0; xif.i_mask = '0; xif.i_wb_ready = 1'b0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    do_op("divu_20_3",  64'd20, 64'd3, 1'b1, 1'b0, 1'b0, 0);
    do_op("remu_20_3",  64'd20, 64'd3, 1'b1, 1'b0, 1'b1, 1);
    do_op("div_m7_2",   -64'sd7, 64'd2, 1'b0, 1'b0, 1'b0, 0);
    do_op("rem_m7_2",   -64'sd7, 64'd2, 1'b0, 1'b0, 1'b1, 0);
    do_op("div_7_m2",   64'd7, -64'sd2, 1'b0, 1'b0, 1'b0, 0);
    do_op("rem_7_m2",   64'd7, -64'sd2, 1'b0, 1'b0, 1'b1, 2);
    do_op("div_by_0",   64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 0);
    do_op("rem_by_0",   64'h1234, 64'd0, 1'b0, 1'b0, 1'b1, 0);
    do_op("div_ovf",    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
    do_op("rem_ovf",    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 0);
    do_op("divw_ovf",   64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 0);
    do_op("divuw_hold", 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b1, 1'b1, 1'b0, 5);

    for (int n = 0; n < 16; n++) begin
      uns  = 1'($urandom);
      word = 1'($urandom);
      rem  = 1'($urandom);
      a    = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       b = {$urandom, $urandom};
        1:       b = 64'($urandom_range(1, 15));
        2:       b = -64'($urandom_range(1, 15));
        3:       b = 64'd0;
        default: begin
          b = 64'hFFFF_FFFF_FFFF_FFFF;
          if (word) a = {$urandom, 32'h8000_0000};
          else      a = 64'h8000_0000_0000_0000;
        end
      endcase
      do_op($sformatf("rand%0d", n), a, b, uns, word, rem, int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a long divide
    pulses0 = retire_pulses;
    @(negedge clk);
    xif.i_valid = 1'b1; xif.i_op1 = 64'd1000; xif.i_op2 = 64'd7;
    xif.i_unsigned = 1'b1; xif.i_word = 1'b0; xif.i_rem = 1'b0;
    xif.i_rd = 5'd9; xif.i_mask = 32'h00F0_0001;
    @(negedge clk);
    xif.i_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midcalc_reset");
    repeat (2) @(negedge clk);
    check("midcalc_reset:held_valid", 64'(xif.o_wb_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midcalc_reset:no_retire", 64'(retire_pulses - pulses0), 64'd0);

    do_op("after_reset_100_10", 64'd100, 64'd10, 1'b1, 1'b0, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
